// File: rtl/eth_phy_pkg.sv
// eth_phy_pkg
//   Shared definitions for the GMII receive path: deframer state encoding,
//   GMII preamble/SFD byte values, default Ethernet length limits and the
//   layout of one stream FIFO entry.
package eth_phy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DROP,
      ST_TERM
   } gmii_rx_state_t;

   localparam logic [7:0] GMII_PREAMBLE = 8'h55;
   localparam logic [7:0] GMII_SFD      = 8'hD5;

   localparam int ETH_MIN_LEN = 64;
   localparam int ETH_MAX_LEN = 1518;

   // One stream entry as stored in the output FIFO.
   typedef struct packed {
      logic       bad;
      logic       last;
      logic [7:0] data;
   } rx_entry_t;

   localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/eth_sync_fifo.sv
// eth_sync_fifo
//   Single-clock FIFO. A read and a write may happen in the same cycle at
//   any level; a write while full is accepted only if a read frees the slot
//   in that same cycle, and a read while empty is ignored.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     wr_en, wr_data     write request / entry
//     rd_en, rd_data     read request / head entry (valid while !empty)
//     level, full, empty occupancy status
module eth_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             rd_ok, wr_ok;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign level   = cnt_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A write while full is legal only when the head leaves in the same cycle.
   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok && !rd_ok) cnt_d = cnt_q + 1'b1;
      else if (!wr_ok && rd_ok) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: nothing is presented while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
//   GMII receive deframer. Strips preamble/SFD, forwards frame bytes through
//   a one-byte holding register into an output FIFO, and marks the final
//   byte with last and a bad flag (GMII error, runt or oversize). If the
//   FIFO runs out of room mid-frame the rest of the frame is discarded and a
//   {0x00, last, bad} terminator closes it.
//   Ports:
//     clk_phy, rst_n_phy                 clock, asynchronous active-low reset
//     phy_rx_dv/err/data                 GMII receive bus
//     mac_rx_data/valid/last/bad/ready   byte stream toward the MAC
//     stat_frame_ok/err/drop             one-cycle frame outcome pulses
//     fifo_level                         output FIFO occupancy
module gmii_rx_deframer
   import eth_phy_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int MIN_LEN    = ETH_MIN_LEN,
   parameter int MAX_LEN    = ETH_MAX_LEN
) (
   input  logic                          clk_phy,
   input  logic                          rst_n_phy,
   input  logic                          phy_rx_dv,
   input  logic                          phy_rx_err,
   input  logic [7:0]                    phy_rx_data,
   output logic [7:0]                    mac_rx_data,
   output logic                          mac_rx_valid,
   output logic                          mac_rx_last,
   output logic                          mac_rx_bad,
   input  logic                          mac_rx_ready,
   output logic                          stat_frame_ok,
   output logic                          stat_frame_err,
   output logic                          stat_frame_drop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   gmii_rx_state_t state_q, state_d;
   logic [7:0]     hold_data_q, hold_data_d;
   logic           hold_vld_q, hold_vld_d;
   logic [10:0]    len_q, len_d;
   logic           bad_q, bad_d;
   logic           stat_ok_q, stat_ok_d;
   logic           stat_err_q, stat_err_d;
   logic           stat_drop_q, stat_drop_d;

   logic           wr_en, rd_en, fifo_full, fifo_empty;
   rx_entry_t      wr_entry, rd_entry;
   logic           room_body, room_last, frame_bad, is_pre, is_sfd;
   logic [10:0]    len_inc;

   assign is_pre = (phy_rx_data == GMII_PREAMBLE);
   assign is_sfd = (phy_rx_data == GMII_SFD);

   // A non-final byte takes one slot and must still leave two free, so the
   // final entry (or overflow terminator) always has somewhere to go.
   assign room_body = (fifo_level <= LW'(FIFO_DEPTH - 3));
   assign room_last = ~fifo_full | rd_en;

   assign len_inc   = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
   assign frame_bad = bad_q | (len_q < 11'(MIN_LEN)) | (len_q > 11'(MAX_LEN));

   // ---------------- state register ----------------
   always_ff @(posedge clk_phy or negedge rst_n_phy) begin
      if (!rst_n_phy) state_q <= ST_DROP;
      else            state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (phy_rx_dv) begin
               if (is_pre)      state_d = ST_PREAMBLE;
               else if (is_sfd) state_d = ST_DATA;
               else             state_d = ST_DROP;
            end
         end
         ST_PREAMBLE: begin
            if (!phy_rx_dv)                           state_d = ST_IDLE;
            else if (phy_rx_err || !(is_pre || is_sfd)) state_d = ST_DROP;
            else if (is_sfd)                          state_d = ST_DATA;
         end
         ST_DATA: begin
            if (!phy_rx_dv)
               state_d = (hold_vld_q && !room_last) ? ST_TERM : ST_IDLE;
            else if (hold_vld_q && !room_body)
               state_d = ST_TERM;
         end
         ST_DROP: begin
            if (!phy_rx_dv) state_d = ST_IDLE;
         end
         ST_TERM: begin
            if (room_last) state_d = phy_rx_dv ? ST_DROP : ST_IDLE;
         end
         default: state_d = ST_DROP;
      endcase
   end

   // ---------------- outputs / datapath ----------------
   always_comb begin
      hold_data_d = hold_data_q;
      hold_vld_d  = hold_vld_q;
      len_d       = len_q;
      bad_d       = bad_q;
      wr_en       = 1'b0;
      wr_entry    = '0;
      stat_ok_d   = 1'b0;
      stat_err_d  = 1'b0;
      stat_drop_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (phy_rx_dv) begin
               if (is_sfd) begin
                  hold_vld_d = 1'b0;
                  len_d      = '0;
                  bad_d      = 1'b0;
               end else if (!is_pre) begin
                  stat_drop_d = 1'b1;
               end
            end
         end
         ST_PREAMBLE: begin
            if (!phy_rx_dv || phy_rx_err || !(is_pre || is_sfd)) begin
               stat_drop_d = 1'b1;
            end else if (is_sfd) begin
               hold_vld_d = 1'b0;
               len_d      = '0;
               bad_d      = 1'b0;
            end
         end
         ST_DATA: begin
            if (phy_rx_dv) begin
               len_d = len_inc;
               bad_d = bad_q | phy_rx_err;
               if (!hold_vld_q) begin
                  hold_data_d = phy_rx_data;
                  hold_vld_d  = 1'b1;
               end else if (room_body) begin
                  wr_en       = 1'b1;
                  wr_entry    = '{bad: 1'b0, last: 1'b0, data: hold_data_q};
                  hold_data_d = phy_rx_data;
               end else begin
                  hold_vld_d = 1'b0;   // held and incoming byte are lost
               end
            end else if (hold_vld_q) begin
               hold_vld_d = 1'b0;
               if (room_last) begin
                  wr_en      = 1'b1;
                  wr_entry   = '{bad: frame_bad, last: 1'b1, data: hold_data_q};
                  stat_ok_d  = ~frame_bad;
                  stat_err_d = frame_bad;
               end
            end else begin
               stat_drop_d = 1'b1;     // SFD followed directly by end of frame
            end
         end
         ST_TERM: begin
            if (room_last) begin
               wr_en      = 1'b1;
               wr_entry   = '{bad: 1'b1, last: 1'b1, data: 8'h00};
               stat_err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_phy or negedge rst_n_phy) begin
      if (!rst_n_phy) begin
         hold_data_q <= '0;
         hold_vld_q  <= 1'b0;
         len_q       <= '0;
         bad_q       <= 1'b0;
         stat_ok_q   <= 1'b0;
         stat_err_q  <= 1'b0;
         stat_drop_q <= 1'b0;
      end else begin
         hold_data_q <= hold_data_d;
         hold_vld_q  <= hold_vld_d;
         len_q       <= len_d;
         bad_q       <= bad_d;
         stat_ok_q   <= stat_ok_d;
         stat_err_q  <= stat_err_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   eth_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RX_ENTRY_W)
   ) u_fifo (
      .clk     (clk_phy),
      .rst_n   (rst_n_phy),
      .wr_en   (wr_en),
      .wr_data (wr_entry),
      .rd_en   (rd_en),
      .rd_data (rd_entry),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign mac_rx_valid = ~fifo_empty;
   assign rd_en        = mac_rx_valid & mac_rx_ready;
   // Stale storage is masked so the stream fields read 0 while empty.
   assign mac_rx_data  = mac_rx_valid ? rd_entry.data : 8'h00;
   assign mac_rx_last  = mac_rx_valid & rd_entry.last;
   assign mac_rx_bad   = mac_rx_valid & rd_entry.bad;

   assign stat_frame_ok   = stat_ok_q;
   assign stat_frame_err  = stat_err_q;
   assign stat_frame_drop = stat_drop_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
module tb_gmii_rx_deframer;

   logic       clk_phy = 1'b0;
   logic       rst_n_phy;
   logic       phy_rx_dv, phy_rx_err;
   logic [7:0] phy_rx_data;
   logic [7:0] mac_rx_data;
   logic       mac_rx_valid, mac_rx_last, mac_rx_bad, mac_rx_ready;
   logic       stat_frame_ok, stat_frame_err, stat_frame_drop;
   logic [4:0] fifo_level;

   gmii_rx_deframer #(.FIFO_DEPTH(16), .MIN_LEN(64), .MAX_LEN(1518)) dut (
      .clk_phy         (clk_phy),
      .rst_n_phy       (rst_n_phy),
      .phy_rx_dv       (phy_rx_dv),
      .phy_rx_err      (phy_rx_err),
      .phy_rx_data     (phy_rx_data),
      .mac_rx_data     (mac_rx_data),
      .mac_rx_valid    (mac_rx_valid),
      .mac_rx_last     (mac_rx_last),
      .mac_rx_bad      (mac_rx_bad),
      .mac_rx_ready    (mac_rx_ready),
      .stat_frame_ok   (stat_frame_ok),
      .stat_frame_err  (stat_frame_err),
      .stat_frame_drop (stat_frame_drop),
      .fifo_level      (fifo_level)
   );

   always #5 clk_phy = ~clk_phy;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- monitor (owned by this block only) ----------------
   logic [9:0] rx_q [$];
   int         n_ok = 0, n_err = 0, n_drop = 0, n_multi = 0, n_unstable = 0;
   logic       stall_q = 1'b0;
   logic [9:0] stall_ent = '0;

   always @(negedge clk_phy) begin
      if (mac_rx_valid && mac_rx_ready) rx_q.push_back({mac_rx_bad, mac_rx_last, mac_rx_data});
      if (stat_frame_ok)   n_ok   <= n_ok + 1;
      if (stat_frame_err)  n_err  <= n_err + 1;
      if (stat_frame_drop) n_drop <= n_drop + 1;
      if (32'(stat_frame_ok) + 32'(stat_frame_err) + 32'(stat_frame_drop) > 1) n_multi <= n_multi + 1;
      if (rst_n_phy && stall_q &&
          (!mac_rx_valid || {mac_rx_bad, mac_rx_last, mac_rx_data} != stall_ent))
         n_unstable <= n_unstable + 1;
      stall_q   <= rst_n_phy & mac_rx_valid & ~mac_rx_ready;
      stall_ent <= {mac_rx_bad, mac_rx_last, mac_rx_data};
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [9:0] exp_q [$];
   int         rx_base, ok0, err0, drop0;

   task automatic begin_test();
      exp_q.delete();
      rx_base = rx_q.size();
      ok0 = n_ok; err0 = n_err; drop0 = n_drop;
   endtask

   task automatic exp_frame(input int n, input logic bad);
      for (int i = 0; i < n; i++) begin
         logic lst;
         lst = (i == n - 1);
         exp_q.push_back({bad & lst, lst, 8'(i)});
      end
   endtask

   task automatic end_test(input string tag, input int eok, input int eerr, input int edrop);
      int got_n, nbad;
      repeat (30) @(posedge clk_phy);
      #1;
      got_n = rx_q.size() - rx_base;
      chk({tag, " count"}, got_n, exp_q.size());
      nbad = 0;
      for (int i = 0; i < exp_q.size() && i < got_n; i++)
         if (rx_q[rx_base + i] !== exp_q[i]) nbad++;
      chk({tag, " entries"}, nbad, 0);
      chk({tag, " ok"},   n_ok - ok0,     eok);
      chk({tag, " err"},  n_err - err0,   eerr);
      chk({tag, " drop"}, n_drop - drop0, edrop);
   endtask

   // ---------------- stimulus ----------------
   task automatic drive(input logic dv, input logic err, input logic [7:0] d);
      phy_rx_dv = dv; phy_rx_err = err; phy_rx_data = d;
      @(posedge clk_phy);
      #1;
   endtask

   task automatic send_frame(input int npre, input int n, input int err_idx);
      for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < n; i++) drive(1'b1, i == err_idx, 8'(i));
      drive(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_phy = 1'b0; mac_rx_ready = 1'b1;
      phy_rx_dv = 1'b0; phy_rx_err = 1'b0; phy_rx_data = 8'h00;
      repeat (3) @(posedge clk_phy);
      #1;
      chk("rst valid", mac_rx_valid, 0);
      chk("rst level", fifo_level, 0);
      chk("rst stats", {stat_frame_ok, stat_frame_err, stat_frame_drop}, 0);
      chk("rst data",  {mac_rx_bad, mac_rx_last, mac_rx_data}, 0);
      rst_n_phy = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);

      // good minimum-length frame
      begin_test(); send_frame(7, 64, -1); exp_frame(64, 1'b0);
      end_test("good64", 1, 0, 0);

      // GMII error on data byte 10
      begin_test(); send_frame(7, 64, 10); exp_frame(64, 1'b1);
      end_test("err64", 0, 1, 0);

      // runts
      begin_test(); send_frame(1, 20, -1); exp_frame(20, 1'b1);
      end_test("runt20", 0, 1, 0);
      begin_test(); send_frame(7, 63, -1); exp_frame(63, 1'b1);
      end_test("runt63", 0, 1, 0);

      // maximum length and oversize
      begin_test(); send_frame(7, 1518, -1); exp_frame(1518, 1'b0);
      end_test("max1518", 1, 0, 0);
      begin_test(); send_frame(7, 1519, -1); exp_frame(1519, 1'b1);
      end_test("over1519", 0, 1, 0);

      // bad SFD after preamble
      begin_test();
      drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h5D);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i));
      drive(1'b0, 1'b0, 8'h00);
      end_test("badsfd", 0, 0, 1);

      // junk first byte
      begin_test();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h12);
      drive(1'b0, 1'b0, 8'h00);
      end_test("junk", 0, 0, 1);

      // SFD then immediate end: empty frame
      begin_test(); send_frame(2, 0, -1);
      end_test("empty", 0, 0, 1);

      // back-to-back with one idle cycle
      begin_test();
      send_frame(7, 64, -1); send_frame(7, 64, -1);
      exp_frame(64, 1'b0); exp_frame(64, 1'b0);
      end_test("b2b", 2, 0, 0);

      // overflow with consumer stalled
      begin_test();
      mac_rx_ready = 1'b0;
      send_frame(7, 64, -1);
      repeat (5) @(posedge clk_phy);
      #1;
      chk("ovf level", fifo_level, 15);
      chk("ovf err pulse", n_err - err0, 1);
      chk("ovf nothing out", rx_q.size() - rx_base, 0);
      mac_rx_ready = 1'b1;
      exp_frame(14, 1'b0);
      exp_q[13] = {1'b0, 1'b0, 8'd13};   // 14 body bytes, none marked last
      exp_q.push_back({1'b1, 1'b1, 8'h00});
      end_test("ovf", 0, 1, 0);
      begin_test(); send_frame(7, 64, -1); exp_frame(64, 1'b0);
      end_test("after ovf", 1, 0, 0);

      // reset mid-frame, released while dv=1
      begin_test();
      mac_rx_ready = 1'b0;
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i));
      chk("pre-rst level", fifo_level, 9);
      rst_n_phy = 1'b0;
      for (int i = 10; i < 13; i++) drive(1'b1, 1'b0, 8'(i));
      chk("in-rst level", fifo_level, 0);
      chk("in-rst valid", mac_rx_valid, 0);
      rst_n_phy = 1'b1;
      for (int i = 13; i < 33; i++) drive(1'b1, 1'b0, 8'(i));
      drive(1'b0, 1'b0, 8'h00);
      mac_rx_ready = 1'b1;
      end_test("midrst", 0, 0, 0);
      begin_test(); send_frame(7, 64, -1); exp_frame(64, 1'b0);
      end_test("after rst", 1, 0, 0);

      chk("stat exclusive", n_multi, 0);
      chk("stream stable", n_unstable, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
